// File: rtl/id_ex_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// id_ex_ctrl_decoder
//
// Decodes RV32I instruction words into an ALU control bundle. Each bundle is
// decoded when the instruction is accepted and held in a 2-entry FIFO, which
// the EX stage drains with a valid/ready handshake.
//
// Ports
//   clk              clock, all state updates on its rising edge
//   reset            asynchronous, active-high reset
//   instr_valid_in   IF/ID instruction valid
//   instr_in         32-bit RV32I instruction word
//   instr_ready_out  decoder can accept an instruction this cycle
//   flush_in         synchronous pipeline flush, discards all buffered entries
//   ex_ready_in      EX-stage control register can accept this cycle
//   ex_valid_out     control bundle at the FIFO head is valid
//   alu_src_out      1 = second operand is the immediate, 0 = register
//   alu_op_out       instruction class (opcode field)
//   alu_func3_out    func3 qualifier
//   alu_func7_out    func7 qualifier
//   illegal_out      head instruction is illegal
//
// FIFO states
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing buffered, outputs all zero
//   ST_ONE   | head entry valid, tail slot free
//   ST_FULL  | head and tail valid, upstream is back-pressured
// -----------------------------------------------------------------------------
module id_ex_ctrl_decoder #(
    parameter int ALU_OP_WIDTH    = 7,
    parameter int ALU_FUNC3_WIDTH = 3,
    parameter int ALU_FUNC7_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_valid_in,
    input  logic [31:0]                instr_in,
    output logic                       instr_ready_out,
    input  logic                       flush_in,
    input  logic                       ex_ready_in,
    output logic                       ex_valid_out,
    output logic                       alu_src_out,
    output logic [ALU_OP_WIDTH-1:0]    alu_op_out,
    output logic [ALU_FUNC3_WIDTH-1:0] alu_func3_out,
    output logic [ALU_FUNC7_WIDTH-1:0] alu_func7_out,
    output logic                       illegal_out
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic                       illegal;
        logic                       alu_src;
        logic [ALU_OP_WIDTH-1:0]    alu_op;
        logic [ALU_FUNC3_WIDTH-1:0] alu_func3;
        logic [ALU_FUNC7_WIDTH-1:0] alu_func7;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  head_q, head_d;
    ctrl_t  tail_q, tail_d;
    ctrl_t  dec;

    logic       push;
    logic       pop;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       legal;
    logic       use_func7;
    logic       use_imm;

    // Register, rd and rs fields play no part in ALU control.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_in[24:15], instr_in[11:7]};

    assign opcode = instr_in[6:0];
    assign func3  = instr_in[14:12];
    assign func7  = instr_in[31:25];

    // ------------------------------------------------------------------
    // Decode. Every legal opcode ends in 2'b11, so a compressed or
    // malformed word falls into the default arm and is flagged illegal.
    // ------------------------------------------------------------------
    always_comb begin
        legal     = 1'b1;
        use_func7 = 1'b0;
        use_imm   = 1'b0;
        case (opcode)
            7'b0110011: use_func7 = 1'b1;
            7'b0010011: begin
                use_imm   = 1'b1;
                // Only the shift-immediates carry a meaningful func7.
                use_func7 = (func3 == 3'b001) || (func3 == 3'b101);
            end
            7'b0000011,
            7'b0100011,
            7'b0110111,
            7'b0010111,
            7'b1101111,
            7'b1100111: use_imm = 1'b1;
            7'b1100011: use_imm = 1'b0;
            default:    legal   = 1'b0;
        endcase

        dec = '0;
        if (legal) begin
            dec.alu_src   = use_imm;
            dec.alu_op    = ALU_OP_WIDTH'(opcode);
            dec.alu_func3 = ALU_FUNC3_WIDTH'(func3);
            dec.alu_func7 = use_func7 ? ALU_FUNC7_WIDTH'(func7) : '0;
        end else begin
            dec.illegal   = 1'b1;
        end
    end

    // Ready comes only from registered state, so there is no
    // combinational path from ex_ready_in back to the fetch side.
    assign push = instr_valid_in && instr_ready_out;
    assign pop  = ex_valid_out && ex_ready_in;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state. Vacated slots are cleared so an empty FIFO always
    // presents an all-zero bundle and nothing stale can resurface.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_in) begin
            state_d = ST_EMPTY;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_d  = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({push, pop})
                        2'b11: head_d = dec;
                        2'b10: begin
                            tail_d  = dec;
                            state_d = ST_FULL;
                        end
                        2'b01: begin
                            head_d  = '0;
                            state_d = ST_EMPTY;
                        end
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    if (pop) begin
                        head_d  = tail_q;
                        tail_d  = '0;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    head_d  = '0;
                    tail_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready_out = (state_q != ST_FULL);
        ex_valid_out    = (state_q != ST_EMPTY);
        alu_src_out     = head_q.alu_src;
        alu_op_out      = head_q.alu_op;
        alu_func3_out   = head_q.alu_func3;
        alu_func7_out   = head_q.alu_func7;
        illegal_out     = head_q.illegal;
    end

endmodule

// File: tb/tb_id_ex_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// tb_id_ex_ctrl_decoder
//
// Directed bench for id_ex_ctrl_decoder. Expected bundles are hand-decoded
// constants packed as {illegal, alu_src, alu_op, func3, func7}.
// -----------------------------------------------------------------------------
module tb_id_ex_ctrl_decoder;

    logic        clk;
    logic        reset;
    logic        instr_valid_in;
    logic [31:0] instr_in;
    logic        instr_ready_out;
    logic        flush_in;
    logic        ex_ready_in;
    logic        ex_valid_out;
    logic        alu_src_out;
    logic [6:0]  alu_op_out;
    logic [2:0]  alu_func3_out;
    logic [6:0]  alu_func7_out;
    logic        illegal_out;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_ctrl_decoder #(
        .ALU_OP_WIDTH    (7),
        .ALU_FUNC3_WIDTH (3),
        .ALU_FUNC7_WIDTH (7)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid_in  (instr_valid_in),
        .instr_in        (instr_in),
        .instr_ready_out (instr_ready_out),
        .flush_in        (flush_in),
        .ex_ready_in     (ex_ready_in),
        .ex_valid_out    (ex_valid_out),
        .alu_src_out     (alu_src_out),
        .alu_op_out      (alu_op_out),
        .alu_func3_out   (alu_func3_out),
        .alu_func7_out   (alu_func7_out),
        .illegal_out     (illegal_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] I_ADD    = 32'h002081B3;
    localparam logic [31:0] I_SUB    = 32'h402081B3;
    localparam logic [31:0] I_ADDI   = 32'h00500093;
    localparam logic [31:0] I_SRAI   = 32'h4030D093;
    localparam logic [31:0] I_SLLI   = 32'h00109093;
    localparam logic [31:0] I_ADDIM1 = 32'hFFF00093;
    localparam logic [31:0] I_LUI    = 32'h123450B7;
    localparam logic [31:0] I_BNE    = 32'hFE209EE3;
    localparam logic [31:0] I_ZERO   = 32'h00000000;
    localparam logic [31:0] I_BADOP  = 32'h0000007F;
    localparam logic [31:0] I_LOW00  = 32'h00500090;

    localparam logic [18:0] B_ADD    = {1'b0, 1'b0, 7'b0110011, 3'b000, 7'b0000000};
    localparam logic [18:0] B_SUB    = {1'b0, 1'b0, 7'b0110011, 3'b000, 7'b0100000};
    localparam logic [18:0] B_ADDI   = {1'b0, 1'b1, 7'b0010011, 3'b000, 7'b0000000};
    localparam logic [18:0] B_SRAI   = {1'b0, 1'b1, 7'b0010011, 3'b101, 7'b0100000};
    localparam logic [18:0] B_SLLI   = {1'b0, 1'b1, 7'b0010011, 3'b001, 7'b0000000};
    localparam logic [18:0] B_LUI    = {1'b0, 1'b1, 7'b0110111, 3'b101, 7'b0000000};
    localparam logic [18:0] B_BNE    = {1'b0, 1'b0, 7'b1100011, 3'b001, 7'b0000000};
    localparam logic [18:0] B_ILL    = {1'b1, 1'b0, 7'b0000000, 3'b000, 7'b0000000};
    localparam logic [18:0] B_NONE   = 19'd0;

    logic [18:0] bundle;
    assign bundle = {illegal_out, alu_src_out, alu_op_out, alu_func3_out, alu_func7_out};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single accept into an empty or draining FIFO, then check the head.
    task automatic push_check(input string tag, input logic [31:0] ins, input logic [18:0] exp);
        instr_valid_in = 1'b1;
        instr_in       = ins;
        step();
        instr_valid_in = 1'b0;
        chk({tag, "_valid"}, 32'(ex_valid_out), 32'd1);
        chk(tag, 32'(bundle), 32'(exp));
    endtask

    initial begin
        reset          = 1'b1;
        instr_valid_in = 1'b0;
        instr_in       = '0;
        flush_in       = 1'b0;
        ex_ready_in    = 1'b1;

        // Reset values, before any clock edge and across a held edge.
        #1;
        chk("rst_valid", 32'(ex_valid_out), 32'd0);
        chk("rst_ready", 32'(instr_ready_out), 32'd1);
        chk("rst_bundle", 32'(bundle), 32'(B_NONE));
        step();
        chk("rst_ready_held", 32'(instr_ready_out), 32'd1);
        reset = 1'b0;

        // add then sub back-to-back with EX always ready.
        push_check("add", I_ADD, B_ADD);
        push_check("sub", I_SUB, B_SUB);
        step();
        chk("drain_valid", 32'(ex_valid_out), 32'd0);
        chk("drain_bundle", 32'(bundle), 32'(B_NONE));

        // I-type, shift-immediate func7 gating and other classes.
        push_check("addi", I_ADDI, B_ADDI);
        push_check("srai", I_SRAI, B_SRAI);
        push_check("slli", I_SLLI, B_SLLI);
        push_check("addi_m1", I_ADDIM1, B_ADDI);
        push_check("lui", I_LUI, B_LUI);
        push_check("bne", I_BNE, B_BNE);

        // Illegal encodings still enqueue and present valid.
        push_check("zero", I_ZERO, B_ILL);
        push_check("badop", I_BADOP, B_ILL);
        push_check("low00", I_LOW00, B_ILL);
        step();
        chk("ill_drain", 32'(ex_valid_out), 32'd0);

        // Stall: A,B fill the FIFO, C is held off, then all drain in order.
        ex_ready_in    = 1'b0;
        instr_valid_in = 1'b1;
        instr_in       = I_ADD;
        step();
        chk("stall_a_head", 32'(bundle), 32'(B_ADD));
        chk("stall_a_ready", 32'(instr_ready_out), 32'd1);
        instr_in = I_SUB;
        step();
        chk("stall_full_ready", 32'(instr_ready_out), 32'd0);
        chk("stall_full_head", 32'(bundle), 32'(B_ADD));
        instr_in = I_ADDI;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_head", 32'(bundle), 32'(B_ADD));
            chk("stall_hold_valid", 32'(ex_valid_out), 32'd1);
            chk("stall_hold_ready", 32'(instr_ready_out), 32'd0);
        end
        ex_ready_in = 1'b1;
        step();
        chk("order_b", 32'(bundle), 32'(B_SUB));
        chk("order_ready", 32'(instr_ready_out), 32'd1);
        step();
        instr_valid_in = 1'b0;
        chk("order_c", 32'(bundle), 32'(B_ADDI));
        step();
        chk("order_empty", 32'(ex_valid_out), 32'd0);

        // Flush from FULL with a simultaneous push and pop.
        ex_ready_in    = 1'b0;
        instr_valid_in = 1'b1;
        instr_in       = I_ADD;
        step();
        instr_in = I_SUB;
        step();
        chk("flush_pre_full", 32'(instr_ready_out), 32'd0);
        flush_in       = 1'b1;
        ex_ready_in    = 1'b1;
        instr_in       = I_SRAI;
        step();
        flush_in       = 1'b0;
        instr_valid_in = 1'b0;
        chk("flush_valid", 32'(ex_valid_out), 32'd0);
        chk("flush_ready", 32'(instr_ready_out), 32'd1);
        step();
        chk("flush_no_ghost", 32'(ex_valid_out), 32'd0);
        chk("flush_bundle", 32'(bundle), 32'(B_NONE));

        // Flush while in ONE with a push: the push is discarded too.
        push_check("pre_flush1", I_LUI, B_LUI);
        flush_in       = 1'b1;
        instr_valid_in = 1'b1;
        instr_in       = I_ADD;
        ex_ready_in    = 1'b0;
        step();
        flush_in       = 1'b0;
        instr_valid_in = 1'b0;
        chk("flush1_valid", 32'(ex_valid_out), 32'd0);

        // Asynchronous reset from FULL, between edges.
        instr_valid_in = 1'b1;
        instr_in       = I_SUB;
        step();
        instr_in = I_SRAI;
        step();
        instr_valid_in = 1'b0;
        chk("arst_pre_full", 32'(instr_ready_out), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(ex_valid_out), 32'd0);
        chk("arst_bundle", 32'(bundle), 32'(B_NONE));
        chk("arst_ready", 32'(instr_ready_out), 32'd1);
        #1;
        reset       = 1'b0;
        ex_ready_in = 1'b1;
        push_check("arst_addi", I_ADDI, B_ADDI);
        step();
        chk("arst_no_stale", 32'(ex_valid_out), 32'd0);
        chk("arst_no_stale_bundle", 32'(bundle), 32'(B_NONE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
